// File: rtl/seg7_pattern_receiver.sv
// seg7_pattern_receiver: receive end of the 7-segment character link.
// Qualifies an active-low segment pattern that must stay stable for
// STABLE_CNT valid samples, decodes it to a 2-bit character code and
// offers it on a single-entry ready/valid buffer. Unknown patterns are
// counted instead of reported.
module seg7_pattern_receiver #(
  parameter int STABLE_CNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       hex_in,
  input  logic             in_valid,
  input  logic             out_ready,
  input  logic             clear_err,
  output logic [1:0]       code_out,
  output logic             out_valid,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             overflow
);

  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STABLE_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic ONE_SHOT = (STABLE_CNT == 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [6:0]    sample, sample_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic [SW-1:0] streak_inc;
  logic          match;
  logic          accept;
  logic [2:0]    dec;
  logic          dec_ok;
  logic [1:0]    dec_code;
  logic          handshake;
  logic          load_ok;
  logic          drop;
  logic          bad;

  // Map a segment pattern to {known, code}; unknown patterns yield known=0.
  function automatic logic [2:0] decode(input logic [6:0] pat);
    case (pat)
      7'h21:   decode = 3'b1_00;
      7'h06:   decode = 3'b1_01;
      7'h79:   decode = 3'b1_10;
      7'h7F:   decode = 3'b1_11;
      default: decode = 3'b0_00;
    endcase
  endfunction

  assign match      = (hex_in == sample);
  assign streak_inc = streak + STREAK_ONE;
  assign dec        = decode(hex_in);
  assign dec_ok     = dec[2];
  assign dec_code   = dec[1:0];

  // Qualifier state, stored sample and streak length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      sample <= 7'h7F;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      sample <= sample_nxt;
      streak <= streak_nxt;
    end
  end

  // Next qualifier state: idle cycles hold everything, a new pattern restarts the streak.
  always_comb begin
    state_nxt  = state;
    sample_nxt = sample;
    streak_nxt = streak;
    if (in_valid) begin
      case (state)
        IDLE: begin
          sample_nxt = hex_in;
          streak_nxt = STREAK_ONE;
          state_nxt  = ONE_SHOT ? LOCKED : QUALIFY;
        end
        QUALIFY: begin
          if (match) begin
            streak_nxt = streak_inc;
            if (streak_inc == STREAK_TOP) state_nxt = LOCKED;
          end else begin
            sample_nxt = hex_in;
            streak_nxt = STREAK_ONE;
            state_nxt  = ONE_SHOT ? LOCKED : QUALIFY;
          end
        end
        LOCKED: begin
          if (!match) begin
            sample_nxt = hex_in;
            streak_nxt = STREAK_ONE;
            state_nxt  = ONE_SHOT ? LOCKED : QUALIFY;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Accept strobe: the sample on this edge completes a stable run not yet reported.
  always_comb begin
    accept = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE:    accept = ONE_SHOT;
        QUALIFY: accept = match ? (streak_inc == STREAK_TOP) : ONE_SHOT;
        LOCKED:  accept = !match && ONE_SHOT;
        default: accept = 1'b0;
      endcase
    end
  end

  assign handshake = out_valid && out_ready;
  assign load_ok   = accept && dec_ok && (!out_valid || out_ready);
  assign drop      = accept && dec_ok && !load_ok;
  assign bad       = accept && !dec_ok;

  // Single-entry output buffer; a reload wins over the consuming handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_out  <= 2'd0;
      out_valid <= 1'b0;
    end else if (load_ok) begin
      code_out  <= dec_code;
      out_valid <= 1'b1;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

  // Error statistics: clear first, then fold in this cycle's error or drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      err_pulse <= bad;
      if (clear_err) begin
        err_count <= bad ? {{(ERR_W-1){1'b0}}, 1'b1} : '0;
        overflow  <= drop;
      end else begin
        if (bad && err_count != ERR_MAX) err_count <= err_count + 1'b1;
        if (drop) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_pattern_receiver.sv
// tb_seg7_pattern_receiver: directed scenarios plus randomized traffic,
// compared every cycle against a run-length reference model.
module tb_seg7_pattern_receiver;

  localparam int STABLE_CNT = 3;
  localparam int ERR_W      = 8;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [6:0]       hex_in;
  logic             in_valid;
  logic             out_ready;
  logic             clear_err;
  logic [1:0]       code_out;
  logic             out_valid;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit   m_have;
  logic [6:0] m_pat;
  int   m_run;
  bit   m_rep;
  bit   m_valid;
  logic [1:0] m_code;
  bit   m_epulse;
  int   m_errc;
  bit   m_ovf;

  seg7_pattern_receiver #(.STABLE_CNT(STABLE_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset_n(reset_n), .hex_in(hex_in), .in_valid(in_valid),
    .out_ready(out_ready), .clear_err(clear_err), .code_out(code_out),
    .out_valid(out_valid), .err_pulse(err_pulse), .err_count(err_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // drive one cycle of inputs at the falling edge, return just after the consuming edge
  task automatic applyStimulus(input logic [6:0] hex, input logic v, input logic rdy,
                               input logic clr, input logic rst_n);
    @(negedge clk);
    hex_in    = hex;
    in_valid  = v;
    out_ready = rdy;
    clear_err = clr;
    reset_n   = rst_n;
    @(posedge clk);
    #2;
  endtask

  function automatic bit known(input logic [6:0] p, output logic [1:0] c);
    case (p)
      7'h21: begin c = 2'd0; return 1'b1; end
      7'h06: begin c = 2'd1; return 1'b1; end
      7'h79: begin c = 2'd2; return 1'b1; end
      7'h7F: begin c = 2'd3; return 1'b1; end
      default: begin c = 2'd0; return 1'b0; end
    endcase
  endfunction

  // model: advance on each rising edge from the inputs seen there, then compare
  always @(posedge clk) begin
    bit acc;
    bit ok;
    logic [1:0] c;
    if (!reset_n) begin
      m_have = 0; m_pat = 7'h7F; m_run = 0; m_rep = 0;
      m_valid = 0; m_code = 0; m_epulse = 0; m_errc = 0; m_ovf = 0;
    end else begin
      acc = 0;
      if (in_valid) begin
        if (m_have && hex_in == m_pat) m_run++;
        else begin
          m_have = 1; m_pat = hex_in; m_run = 1; m_rep = 0;
        end
        if (!m_rep && m_run >= STABLE_CNT) begin
          acc = 1; m_rep = 1;
        end
      end
      ok = known(hex_in, c);
      if (clear_err) begin
        m_errc = 0; m_ovf = 0;
      end
      m_epulse = acc && !ok;
      if (m_epulse && m_errc < ERR_MAX) m_errc++;
      if (acc && ok) begin
        if (!m_valid || out_ready) begin
          m_valid = 1; m_code = c;
        end else m_ovf = 1;
      end else if (m_valid && out_ready) m_valid = 0;
    end
    #1;
    checkOutput("model_out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) checkOutput("model_code_out", 32'(code_out), 32'(m_code));
    checkOutput("model_err_pulse", 32'(err_pulse), 32'(m_epulse));
    checkOutput("model_err_count", 32'(err_count), 32'(m_errc));
    checkOutput("model_overflow", 32'(overflow), 32'(m_ovf));
  end

  initial begin
    logic [6:0] pat;
    logic [6:0] pool [6];
    pool[0] = 7'h21; pool[1] = 7'h06; pool[2] = 7'h79;
    pool[3] = 7'h7F; pool[4] = 7'h00; pool[5] = 7'h5A;

    reset_n = 1'b0; hex_in = 7'h00; in_valid = 0; out_ready = 0; clear_err = 0;

    // T1 reset state
    @(posedge clk); @(posedge clk); #2;
    checkOutput("t1_code_out", 32'(code_out), 0);
    checkOutput("t1_out_valid", 32'(out_valid), 0);
    checkOutput("t1_err_count", 32'(err_count), 0);
    checkOutput("t1_overflow", 32'(overflow), 0);
    checkOutput("t1_err_pulse", 32'(err_pulse), 0);

    // T2 E qualifies once, no repeat reports
    applyStimulus(7'h06, 1, 1, 0, 1);
    applyStimulus(7'h06, 1, 1, 0, 1);
    checkOutput("t2_not_yet", 32'(out_valid), 0);
    applyStimulus(7'h06, 1, 1, 0, 1);
    checkOutput("t2_out_valid", 32'(out_valid), 1);
    checkOutput("t2_code_out", 32'(code_out), 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(7'h06, 1, 1, 0, 1);
      checkOutput("t2_no_repeat", 32'(out_valid), 0);
    end

    // T3 broken streak and idle gaps
    applyStimulus(7'h21, 1, 1, 0, 1);
    applyStimulus(7'h21, 1, 1, 0, 1);
    applyStimulus(7'h79, 1, 1, 0, 1);
    applyStimulus(7'h21, 0, 1, 0, 1);
    applyStimulus(7'h00, 0, 1, 0, 1);
    applyStimulus(7'h79, 1, 1, 0, 1);
    checkOutput("t3_no_code0", 32'(out_valid), 0);
    applyStimulus(7'h79, 1, 1, 0, 1);
    checkOutput("t3_out_valid", 32'(out_valid), 1);
    checkOutput("t3_code_out", 32'(code_out), 2);
    applyStimulus(7'h79, 0, 1, 0, 1);

    // T4 full buffer drops the second code
    for (int i = 0; i < 3; i++) applyStimulus(7'h21, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(7'h7F, 1, 0, 0, 1);
    checkOutput("t4_code_out", 32'(code_out), 0);
    checkOutput("t4_out_valid", 32'(out_valid), 1);
    checkOutput("t4_overflow", 32'(overflow), 1);
    applyStimulus(7'h7F, 0, 1, 0, 1);
    checkOutput("t4_drained", 32'(out_valid), 0);

    // T5 invalid patterns, saturation, clear
    applyStimulus(7'h00, 1, 1, 0, 1);
    applyStimulus(7'h00, 1, 1, 0, 1);
    applyStimulus(7'h00, 1, 1, 0, 1);
    checkOutput("t5_err_pulse", 32'(err_pulse), 1);
    checkOutput("t5_err_count", 32'(err_count), 1);
    checkOutput("t5_no_valid", 32'(out_valid), 0);
    applyStimulus(7'h00, 1, 1, 0, 1);
    checkOutput("t5_pulse_once", 32'(err_pulse), 0);
    for (int i = 0; i < 300; i++) begin
      pat = (i % 2 == 0) ? 7'h01 : 7'h00;
      for (int k = 0; k < 3; k++) applyStimulus(pat, 1, 1, 0, 1);
    end
    checkOutput("t5_saturated", 32'(err_count), 255);
    applyStimulus(7'h00, 0, 1, 1, 1);
    checkOutput("t5_cleared", 32'(err_count), 0);
    checkOutput("t5_ovf_cleared", 32'(overflow), 0);
    applyStimulus(7'h02, 1, 1, 0, 1);
    applyStimulus(7'h02, 1, 1, 0, 1);
    applyStimulus(7'h02, 1, 1, 1, 1);
    checkOutput("t5_clear_with_err", 32'(err_count), 1);

    // T6 reset discards a partial streak
    applyStimulus(7'h79, 1, 1, 0, 1);
    applyStimulus(7'h79, 1, 1, 0, 1);
    applyStimulus(7'h79, 0, 1, 0, 0);
    applyStimulus(7'h79, 1, 1, 0, 1);
    checkOutput("t6_after_reset", 32'(out_valid), 0);
    applyStimulus(7'h79, 1, 1, 0, 1);
    checkOutput("t6_still_qualifying", 32'(out_valid), 0);
    applyStimulus(7'h79, 1, 1, 0, 1);
    checkOutput("t6_out_valid", 32'(out_valid), 1);
    checkOutput("t6_code_out", 32'(code_out), 2);

    // randomized traffic, checked only by the per-cycle model
    pat = 7'h21;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 25) begin
        if ($urandom_range(0, 9) == 0) pat = 7'($urandom);
        else pat = pool[$urandom_range(0, 5)];
      end
      applyStimulus(pat, $urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 199) != 0);
    end
    applyStimulus(7'h00, 0, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
